// File: rtl/regfile_sequencer_pkg.sv
// Shared definitions for the register-file operand sequencer: FSM state
// encoding, register-file command values and default widths.
package regfile_sequencer_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    // Register-file command carried on rf_sal
    localparam logic RF_READ  = 1'b0;
    localparam logic RF_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        CAP_B,
        OP_OUT,
        WAIT_RES,
        WB
    } state_t;

endpackage

// File: rtl/regfile_sequencer_if.sv
// Bus bundle between the sequencer and its environment: instruction
// request, register-file port, ALU operand and ALU result handshakes.
interface regfile_sequencer_if #(
    parameter int DATA_W = regfile_sequencer_pkg::DEF_DATA_W,
    parameter int ADDR_W = regfile_sequencer_pkg::DEF_ADDR_W
) ();

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_rs1;
    logic [ADDR_W-1:0] req_rs2;
    logic [ADDR_W-1:0] req_rd;
    logic              req_wb;

    logic [ADDR_W-1:0] rf_addr;
    logic              rf_sal;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata;

    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;

    logic              busy;

    // Sequencer side
    modport master (
        input  req_valid, req_rs1, req_rs2, req_rd, req_wb,
        output req_ready,
        output rf_addr, rf_sal, rf_wdata,
        input  rf_rdata,
        output op_valid, op_a, op_b,
        input  op_ready,
        input  res_valid, res_data,
        output res_ready,
        output busy
    );

    // Environment side: instruction source, register file and ALU
    modport slave (
        output req_valid, req_rs1, req_rs2, req_rd, req_wb,
        input  req_ready,
        input  rf_addr, rf_sal, rf_wdata,
        output rf_rdata,
        input  op_valid, op_a, op_b,
        output op_ready,
        output res_valid, res_data,
        input  res_ready,
        input  busy
    );

endinterface

// File: rtl/regfile_sequencer.sv
// Register-file operand sequencer: reads two source registers through a
// single-port register file with one-cycle read latency, presents them to
// the ALU, waits for the result and optionally writes it back.
module regfile_sequencer
    import regfile_sequencer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic               clkout,
    input  logic               rst,
    regfile_sequencer_if.master bus
);

    state_t            state;

    // Instruction fields latched at accept
    logic [ADDR_W-1:0] rs1_q;
    logic [ADDR_W-1:0] rs2_q;
    logic [ADDR_W-1:0] rd_q;
    logic              wb_q;

    // Registered outputs
    logic              req_ready_q;
    logic              op_valid_q;
    logic              res_ready_q;
    logic [ADDR_W-1:0] rf_addr_q;
    logic              rf_sal_q;
    logic [DATA_W-1:0] rf_wdata_q;
    logic [DATA_W-1:0] op_a_q;
    logic [DATA_W-1:0] op_b_q;

    assign bus.req_ready = req_ready_q;
    assign bus.op_valid  = op_valid_q;
    assign bus.res_ready = res_ready_q;
    assign bus.rf_addr   = rf_addr_q;
    assign bus.rf_sal    = rf_sal_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.op_a      = op_a_q;
    assign bus.op_b      = op_b_q;
    assign bus.busy      = (state != IDLE);

    // Sequencer FSM with registered outputs. Outputs are loaded on the edge
    // that enters a state, so the addressed register appears during RD_A/RD_B
    // and its data (one cycle later) is captured leaving RD_B/CAP_B.
    always_ff @(posedge clkout or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            wb_q        <= 1'b0;
            req_ready_q <= 1'b1;
            op_valid_q  <= 1'b0;
            res_ready_q <= 1'b0;
            rf_addr_q   <= '0;
            rf_sal_q    <= RF_READ;
            rf_wdata_q  <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        rs1_q       <= bus.req_rs1;
                        rs2_q       <= bus.req_rs2;
                        rd_q        <= bus.req_rd;
                        wb_q        <= bus.req_wb;
                        rf_addr_q   <= bus.req_rs1;
                        rf_sal_q    <= RF_READ;
                        req_ready_q <= 1'b0;
                        state       <= RD_A;
                    end
                end
                RD_A: begin
                    rf_addr_q <= rs2_q;
                    state     <= RD_B;
                end
                RD_B: begin
                    // rs1 data is on rf_rdata now; register 0 reads as zero
                    op_a_q <= (rs1_q == '0) ? '0 : bus.rf_rdata;
                    state  <= CAP_B;
                end
                CAP_B: begin
                    op_b_q     <= (rs2_q == '0) ? '0 : bus.rf_rdata;
                    op_valid_q <= 1'b1;
                    state      <= OP_OUT;
                end
                OP_OUT: begin
                    if (bus.op_ready) begin
                        op_valid_q  <= 1'b0;
                        res_ready_q <= 1'b1;
                        state       <= WAIT_RES;
                    end
                end
                WAIT_RES: begin
                    if (bus.res_valid) begin
                        res_ready_q <= 1'b0;
                        rf_wdata_q  <= bus.res_data;
                        // Register 0 is hard-wired: never issue a write to it
                        if (wb_q && (rd_q != '0)) begin
                            rf_addr_q <= rd_q;
                            rf_sal_q  <= RF_WRITE;
                            state     <= WB;
                        end else begin
                            req_ready_q <= 1'b1;
                            state       <= IDLE;
                        end
                    end
                end
                WB: begin
                    rf_sal_q    <= RF_READ;
                    req_ready_q <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    op_valid_q  <= 1'b0;
                    res_ready_q <= 1'b0;
                    rf_sal_q    <= RF_READ;
                    req_ready_q <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: register-file and ALU models around the DUT,
// directed scenarios followed by randomized instruction streams checked
// against an architectural register array.
module tb_regfile_sequencer;
    import regfile_sequencer_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    logic clkout = 1'b0;
    logic rst    = 1'b1;
    logic mem_clr = 1'b1;

    always #5 clkout = ~clkout;

    regfile_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    regfile_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clkout (clkout),
        .rst    (rst),
        .bus    (bus.master)
    );

    // Register file: registered read, write on rf_sal
    logic [DW-1:0] mem [32];
    int wr_count  = 0;
    int wr0_count = 0;

    always @(posedge clkout) begin
        if (mem_clr) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
            bus.rf_rdata <= '0;
        end else begin
            bus.rf_rdata <= mem[bus.rf_addr];
            if (bus.rf_sal) begin
                mem[bus.rf_addr] <= bus.rf_wdata;
                wr_count <= wr_count + 1;
                if (bus.rf_addr == '0) wr0_count <= wr0_count + 1;
            end
        end
    end

    // Architectural register state expected after each instruction
    logic [DW-1:0] ref_rf [32];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one instruction starting at a negedge and returns at the negedge
    // where the sequencer is idle again. With pend set, the next request is
    // raised while this one waits for its result.
    task automatic run_instr(
        input logic [AW-1:0] s1, input logic [AW-1:0] s2, input logic [AW-1:0] d,
        input logic w, input logic [DW-1:0] result, input int hold, input int rdly,
        input bit pend, input logic [AW-1:0] n1, input logic [AW-1:0] n2,
        input logic [AW-1:0] nd, input logic nw,
        output logic [DW-1:0] got_a, output logic [DW-1:0] got_b);
        logic [DW-1:0] ea, eb;
        bit do_wr;
        int cyc, w0;
        ea    = (s1 == 0) ? '0 : ref_rf[s1];
        eb    = (s2 == 0) ? '0 : ref_rf[s2];
        do_wr = w && (d != 0);

        bus.req_valid = 1'b1;
        bus.req_rs1 = s1; bus.req_rs2 = s2; bus.req_rd = d; bus.req_wb = w;
        cyc = 0;
        while (!bus.req_ready && cyc < 50) begin @(negedge clkout); cyc++; end
        chk("req_ready_before_accept", bus.req_ready, 1);
        @(posedge clkout);
        w0 = wr_count;
        @(negedge clkout);
        bus.req_valid = 1'b0;
        chk("busy_after_accept", bus.busy, 1);
        chk("req_ready_after_accept", bus.req_ready, 0);
        cyc = 1;
        while (!bus.op_valid && cyc < 20) begin @(negedge clkout); cyc++; end
        chk("op_valid_latency", cyc, 4);
        chk("op_a", bus.op_a, ea);
        chk("op_b", bus.op_b, eb);
        got_a = bus.op_a;
        got_b = bus.op_b;

        repeat (hold) begin
            @(negedge clkout);
            chk("op_valid_held", bus.op_valid, 1);
            chk("op_a_stable", bus.op_a, ea);
            chk("op_b_stable", bus.op_b, eb);
            chk("res_ready_in_op_out", bus.res_ready, 0);
        end
        bus.op_ready = 1'b1;
        @(posedge clkout);
        @(negedge clkout);
        bus.op_ready = 1'b0;
        chk("op_valid_dropped", bus.op_valid, 0);
        chk("res_ready", bus.res_ready, 1);
        if (pend) begin
            bus.req_valid = 1'b1;
            bus.req_rs1 = n1; bus.req_rs2 = n2; bus.req_rd = nd; bus.req_wb = nw;
            chk("req_ready_while_busy", bus.req_ready, 0);
        end
        repeat (rdly) begin
            @(negedge clkout);
            chk("res_ready_waiting", bus.res_ready, 1);
        end
        bus.res_valid = 1'b1;
        bus.res_data  = result;
        @(posedge clkout);
        @(negedge clkout);
        bus.res_valid = 1'b0;
        chk("res_ready_dropped", bus.res_ready, 0);
        if (do_wr) begin
            chk("wb_sal", bus.rf_sal, 1);
            chk("wb_addr", bus.rf_addr, d);
            chk("wb_data", bus.rf_wdata, result);
            chk("wb_req_ready", bus.req_ready, 0);
            @(negedge clkout);
        end
        chk("sal_idle", bus.rf_sal, 0);
        chk("busy_idle", bus.busy, 0);
        chk("req_ready_idle", bus.req_ready, 1);
        chk("write_count", wr_count - w0, do_wr ? 1 : 0);
        if (do_wr) ref_rf[d] = result;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] ga, gb;
        logic [AW-1:0] c1, c2, cd, x1, x2, xd;
        logic cw, xw;
        bit pend;
        int w0, cyc;

        for (int i = 0; i < 32; i++) ref_rf[i] = '0;
        bus.req_valid = 0; bus.req_rs1 = 0; bus.req_rs2 = 0; bus.req_rd = 0; bus.req_wb = 0;
        bus.op_ready = 0; bus.res_valid = 0; bus.res_data = 0;

        // Reset state
        repeat (3) @(negedge clkout);
        rst = 1'b0;
        mem_clr = 1'b0;
        @(negedge clkout);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_op_valid", bus.op_valid, 0);
        chk("rst_res_ready", bus.res_ready, 0);
        chk("rst_rf_sal", bus.rf_sal, 0);
        chk("rst_rf_addr", bus.rf_addr, 0);
        chk("rst_rf_wdata", bus.rf_wdata, 0);
        chk("rst_op_a", bus.op_a, 0);
        chk("rst_op_b", bus.op_b, 0);

        // Preload r3, r4, r7 through the sequencer's own write-back
        run_instr(0, 0, 3, 1, 32'h11, 0, 0, 0, 0, 0, 0, 0, ga, gb);
        run_instr(0, 0, 4, 1, 32'h22, 0, 0, 0, 0, 0, 0, 0, ga, gb);
        run_instr(0, 0, 7, 1, 32'hFF, 0, 0, 0, 0, 0, 0, 0, ga, gb);

        // r5 = r3 op r4, then read r5 back
        run_instr(3, 4, 5, 1, 32'h33, 0, 0, 0, 0, 0, 0, 0, ga, gb);
        chk("basic_op_a", ga, 32'h11);
        chk("basic_op_b", gb, 32'h22);
        run_instr(5, 0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 0, 0, ga, gb);
        chk("r5_readback", ga, 32'h33);

        // Zero source forced, op_ready held low for 5 cycles
        run_instr(0, 7, 8, 0, 32'h55, 5, 0, 0, 0, 0, 0, 0, ga, gb);
        chk("zero_src_a", ga, 32'h0);
        chk("zero_src_b", gb, 32'hFF);

        // Write-back to register 0 is suppressed
        run_instr(3, 4, 0, 1, 32'hAA, 0, 0, 0, 0, 0, 0, 0, ga, gb);
        chk("rd0_no_write", wr0_count, 0);

        // Dependent back-to-back pair with the second request pending
        run_instr(2, 2, 2, 1, 32'h10, 0, 0, 1, 2, 0, 6, 1, ga, gb);
        chk("dep_first_pre_write", ga, 32'h0);
        run_instr(2, 0, 6, 1, 32'h05, 0, 0, 0, 0, 0, 0, 0, ga, gb);
        chk("dep_second_op_a", ga, 32'h10);
        chk("dep_second_op_b", gb, 32'h0);

        // Reset during WAIT_RES abandons the instruction
        bus.req_valid = 1'b1;
        bus.req_rs1 = 3; bus.req_rs2 = 4; bus.req_rd = 9; bus.req_wb = 1;
        @(posedge clkout);
        @(negedge clkout);
        bus.req_valid = 1'b0;
        cyc = 1;
        while (!bus.op_valid && cyc < 20) begin @(negedge clkout); cyc++; end
        chk("rstmid_op_valid", bus.op_valid, 1);
        bus.op_ready = 1'b1;
        @(posedge clkout);
        @(negedge clkout);
        bus.op_ready = 1'b0;
        chk("rstmid_wait_res", bus.res_ready, 1);
        w0 = wr_count;
        rst = 1'b1;
        #1;
        chk("rstmid_busy", bus.busy, 0);
        chk("rstmid_op_valid_clr", bus.op_valid, 0);
        chk("rstmid_res_ready_clr", bus.res_ready, 0);
        chk("rstmid_rf_sal", bus.rf_sal, 0);
        chk("rstmid_rf_addr", bus.rf_addr, 0);
        chk("rstmid_op_a", bus.op_a, 0);
        @(negedge clkout);
        rst = 1'b0;
        bus.res_valid = 1'b1;
        bus.res_data  = 32'h77;
        @(negedge clkout);
        bus.res_valid = 1'b0;
        chk("rstmid_req_ready", bus.req_ready, 1);
        chk("rstmid_idle", bus.busy, 0);
        repeat (3) @(negedge clkout);
        chk("rstmid_no_write", wr_count - w0, 0);

        // Randomized instruction stream
        c1 = AW'($urandom_range(0, 31)); c2 = AW'($urandom_range(0, 31));
        cd = AW'($urandom_range(0, 31)); cw = 1'($urandom_range(0, 1));
        for (int k = 0; k < 60; k++) begin
            x1 = AW'($urandom_range(0, 31)); x2 = AW'($urandom_range(0, 31));
            xd = AW'($urandom_range(0, 31)); xw = 1'($urandom_range(0, 3) != 0);
            pend = (k != 59) && ($urandom_range(0, 1) == 1);
            run_instr(c1, c2, cd, cw, $urandom, $urandom_range(0, 3), $urandom_range(0, 2),
                      pend, x1, x2, xd, xw, ga, gb);
            c1 = x1; c2 = x2; cd = xd; cw = xw;
        end

        // Final register-file contents against the architectural model
        for (int i = 1; i < 32; i++) chk($sformatf("final_r%0d", i), mem[i], ref_rf[i]);
        chk("final_no_r0_write", wr0_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
